// File: rtl/lc2k_mem_arbiter_if.sv
// Shared-memory port bundle: fetch requester, load/store requester and the
// single-port synchronous-read memory, as seen from either side of the arbiter.
interface lc2k_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
);
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_ack;
  logic [DATA_W-1:0] if_rdata;

  logic              d_req;
  logic              d_we;
  logic [ADDR_W-1:0] d_addr;
  logic [DATA_W-1:0] d_wdata;
  logic              d_ack;
  logic [DATA_W-1:0] d_rdata;

  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              busy;

  // Requesters and memory side.
  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    input  if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );

  // Arbiter side.
  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, mem_rdata,
    output if_ack, if_rdata, d_ack, d_rdata, mem_en, mem_we, mem_addr, mem_wdata, busy
  );
endinterface

// File: rtl/lc2k_mem_arbiter.sv
// Grants the shared LC2K memory port to fetch or load/store, one 2-cycle access
// at a time; data has priority but fetch wins after MAX_WAIT consecutive losses.
module lc2k_mem_arbiter #(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 32,
  parameter int MAX_WAIT = 3
) (
  input  logic                clk,
  input  logic                reset,
  lc2k_mem_arbiter_if.slave   bus
);
  typedef enum logic [1:0] {IDLE, WAIT_IF, WAIT_D} state_t;

  localparam logic [3:0] MAXW = 4'(MAX_WAIT);

  state_t     r_state, w_next;
  logic [3:0] r_wait_cnt;
  logic       r_we;
  logic       w_if_win, w_d_win;

  assign w_if_win = bus.if_req && (!bus.d_req || (r_wait_cnt == MAXW));
  assign w_d_win  = bus.d_req && !w_if_win;

  always_comb begin
    w_next        = r_state;
    bus.if_ack    = 1'b0;
    bus.if_rdata  = '0;
    bus.d_ack     = 1'b0;
    bus.d_rdata   = '0;
    bus.mem_en    = 1'b0;
    bus.mem_we    = 1'b0;
    bus.mem_addr  = '0;
    bus.mem_wdata = '0;
    bus.busy      = 1'b0;
    case (r_state)
      IDLE: begin
        // Reset gating keeps every output at 0 while reset is held.
        if (!reset) begin
          if (w_if_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_addr  = bus.if_addr;
            bus.mem_wdata = bus.d_wdata;
            w_next        = WAIT_IF;
          end else if (w_d_win) begin
            bus.mem_en    = 1'b1;
            bus.mem_we    = bus.d_we;
            bus.mem_addr  = bus.d_addr;
            bus.mem_wdata = bus.d_wdata;
            w_next        = WAIT_D;
          end
        end
      end
      WAIT_IF: begin
        w_next = IDLE;
        if (!reset) begin
          bus.if_ack   = 1'b1;
          bus.if_rdata = bus.mem_rdata;
          bus.busy     = 1'b1;
        end
      end
      default: begin
        w_next = IDLE;
        if (!reset) begin
          bus.d_ack   = 1'b1;
          bus.d_rdata = r_we ? '0 : bus.mem_rdata;
          bus.busy    = 1'b1;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_wait_cnt <= '0;
      r_we       <= 1'b0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_d_win)
        r_we <= bus.d_we;
      // Counts fetch losses to data; saturation at MAXW forces the next fetch grant.
      if (!bus.if_req || (r_state == IDLE && w_if_win))
        r_wait_cnt <= '0;
      else if (r_state == IDLE && w_d_win && r_wait_cnt != MAXW)
        r_wait_cnt <= r_wait_cnt + 4'd1;
    end
  end
endmodule

// File: tb/tb_lc2k_mem_arbiter.sv
// Directed bench for lc2k_mem_arbiter: expected acks go into a scoreboard queue,
// a negedge monitor pops and checks them against every ack the DUT produces.
module tb_lc2k_mem_arbiter;
  logic clk = 1'b0;
  logic reset;
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  typedef struct {
    bit          is_d;
    logic [31:0] data;
    int          cyc;
  } exp_t;
  exp_t sb[$];

  lc2k_mem_arbiter_if #(.ADDR_W(16), .DATA_W(32)) bus();

  lc2k_mem_arbiter #(.ADDR_W(16), .DATA_W(32), .MAX_WAIT(3)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: synchronous read, 16 words, pattern reloaded by reset.
  logic [31:0] mem [0:15];
  logic [31:0] r_mrd = '0;
  assign bus.mem_rdata = r_mrd;
  always @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) mem[i] <= 32'hA000_0000 + i;
      mem[5] <= 32'd16842749;
    end else if (bus.mem_en) begin
      if (bus.mem_we) mem[bus.mem_addr[3:0]] <= bus.mem_wdata;
      else            r_mrd <= mem[bus.mem_addr[3:0]];
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input bit is_d, input logic [31:0] data, input int c);
    exp_t e;
    e.is_d = is_d; e.data = data; e.cyc = c;
    sb.push_back(e);
  endtask

  // Monitor: every ack must match the head of the scoreboard.
  always @(negedge clk) begin
    if (bus.if_ack && bus.d_ack) chk("both_acks", 64'd1, 64'd0);
    if (bus.if_ack || bus.d_ack) begin
      if (sb.size() == 0) begin
        chk("unexpected_ack", {62'd0, bus.d_ack, bus.if_ack}, 64'd0);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("ack_kind",  {63'd0, bus.d_ack}, {63'd0, e.is_d});
        chk("ack_data",  {32'd0, (bus.d_ack ? bus.d_rdata : bus.if_rdata)}, {32'd0, e.data});
        chk("ack_cycle", 64'(cyc), 64'(e.cyc));
      end
    end
  end

  initial begin
    int t;
    reset = 1'b1;
    bus.if_req = 1'b0; bus.if_addr = '0;
    bus.d_req = 1'b0; bus.d_we = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;

    // Reset state.
    tick(); tick();
    @(negedge clk);
    chk("rst_outputs", {63'd0, |{bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata, bus.mem_en,
        bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy}}, 64'd0);
    chk("rst_wait_cnt", {60'd0, dut.r_wait_cnt}, 64'd0);
    reset = 1'b0;

    // Single fetch.
    tick(); t = cyc;
    bus.if_req = 1'b1; bus.if_addr = 16'd5;
    push(1'b0, 32'd16842749, t + 1);
    @(negedge clk);
    chk("f1_mem_en", {63'd0, bus.mem_en}, 64'd1);
    chk("f1_mem_addr", {48'd0, bus.mem_addr}, 64'd5);
    chk("f1_busy_t", {63'd0, bus.busy}, 64'd0);
    tick(); bus.if_req = 1'b0;
    @(negedge clk);
    chk("f1_busy_t1", {63'd0, bus.busy}, 64'd1);
    chk("f1_mem_en_t1", {63'd0, bus.mem_en}, 64'd0);
    tick();
    @(negedge clk);
    chk("f1_busy_t2", {63'd0, bus.busy}, 64'd0);

    // Store then load.
    tick(); t = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b1; bus.d_addr = 16'd10; bus.d_wdata = 32'hDEADBEEF;
    push(1'b1, 32'd0, t + 1);
    @(negedge clk);
    chk("st_mem_we", {63'd0, bus.mem_we}, 64'd1);
    chk("st_mem_addr", {48'd0, bus.mem_addr}, 64'd10);
    chk("st_mem_wdata", {32'd0, bus.mem_wdata}, 64'hDEADBEEF);
    tick(); bus.d_req = 1'b0;
    @(negedge clk);
    chk("st_mem_we_t1", {63'd0, bus.mem_we}, 64'd0);
    chk("st_idle_wdata", {32'd0, bus.mem_wdata}, 64'd0);
    tick(); t = cyc;
    bus.d_req = 1'b1; bus.d_we = 1'b0;
    push(1'b1, 32'hDEADBEEF, t + 1);
    @(negedge clk);
    chk("ld_mem_we", {63'd0, bus.mem_we}, 64'd0);
    tick(); bus.d_req = 1'b0;
    tick();

    // Starvation bound: D, D, D, IF repeated.
    tick(); t = cyc;
    bus.if_req = 1'b1; bus.if_addr = 16'd5;
    bus.d_req = 1'b1; bus.d_we = 1'b0; bus.d_addr = 16'd10;
    for (int g = 0; g < 8; g++) begin
      if (g % 4 == 3) push(1'b0, 32'd16842749, t + 2*g + 1);
      else            push(1'b1, 32'hDEADBEEF, t + 2*g + 1);
    end
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      if (k % 2 == 0) begin
        chk("sv_mem_en", {63'd0, bus.mem_en}, 64'd1);
        chk("sv_mem_addr", {48'd0, bus.mem_addr}, ((k/2) % 4 == 3) ? 64'd5 : 64'd10);
      end
      tick();
    end
    bus.if_req = 1'b0; bus.d_req = 1'b0;
    tick();

    // Reset in WAIT_D: ack suppressed, wait_cnt cleared.
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'd5; bus.d_req = 1'b1; bus.d_addr = 16'd10;
    tick(); reset = 1'b1;
    @(negedge clk);
    chk("rd_wait_cnt_pre", {60'd0, dut.r_wait_cnt}, 64'd1);
    chk("rd_d_ack", {63'd0, bus.d_ack}, 64'd0);
    tick(); reset = 1'b0; bus.if_req = 1'b0; bus.d_req = 1'b0;
    @(negedge clk);
    chk("rd_wait_cnt", {60'd0, dut.r_wait_cnt}, 64'd0);

    // Reset in WAIT_IF.
    tick();
    bus.if_req = 1'b1; bus.if_addr = 16'd5;
    tick(); reset = 1'b1; bus.if_req = 1'b0;
    @(negedge clk);
    chk("ri_if_ack", {63'd0, bus.if_ack}, 64'd0);
    chk("ri_busy", {63'd0, bus.busy}, 64'd0);
    tick(); reset = 1'b0;
    @(negedge clk);
    chk("ri_outputs", {63'd0, |{bus.if_ack, bus.d_ack, bus.if_rdata, bus.d_rdata, bus.mem_en,
        bus.mem_we, bus.mem_addr, bus.mem_wdata, bus.busy}}, 64'd0);
    chk("ri_wait_cnt", {60'd0, dut.r_wait_cnt}, 64'd0);

    // Held request across three fetches.
    tick(); t = cyc;
    bus.if_req = 1'b1; bus.if_addr = 16'd0;
    push(1'b0, 32'hA000_0000, t + 1);
    push(1'b0, 32'hA000_0001, t + 3);
    push(1'b0, 32'hA000_0002, t + 5);
    tick(); bus.if_addr = 16'd1;
    tick();
    tick(); bus.if_addr = 16'd2;
    tick();
    tick(); bus.if_req = 1'b0;
    tick(); tick();

    @(negedge clk);
    chk("sb_drained", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
